// File: rtl/mmio_pkg.sv
// Address map and status bit layout for the I/O region.
// The core's writeback mux decodes I/O reads with the same constants.
package mmio_pkg;

    localparam logic [7:0] MMIO_STATUS  = 8'h00;
    localparam logic [7:0] MMIO_RX      = 8'h04;
    localparam logic [7:0] MMIO_TX      = 8'h08;
    localparam logic [7:0] MMIO_CYC     = 8'h10;
    localparam logic [7:0] MMIO_INST    = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST = 8'h18;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_RX_FULL  = 1;

    function automatic logic [31:0] status_word(input logic tx_pend, input logic rx_full);
        logic [31:0] w;
        w = 32'h0;
        w[STAT_TX_EMPTY] = ~tx_pend;
        w[STAT_RX_FULL]  = rx_full;
        return w;
    endfunction

endpackage

// File: rtl/mmio_counter.sv
// Free-running counter with a synchronous clear that takes priority over the increment.
module mmio_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// I/O-region decode for the memory stage: UART RX/TX byte buffers plus cycle and
// retired-instruction counters, with one-cycle registered load data.
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter logic [3:0] IO_TAG    = 4'h8,
    parameter int         CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [3:0]  wbe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    // Both UART links use valid/ready: a byte moves on a clock edge where valid and
    // ready are both high; the producer holds valid and data stable until then.

    logic                 sel;
    logic [7:0]           off;
    logic                 rd_en;
    logic                 wr_en;
    logic                 rx_full;
    logic [7:0]           rx_buf;
    logic                 tx_pend;
    logic [7:0]           tx_buf;
    logic                 cnt_clr;
    logic [CNT_WIDTH-1:0] cyc_cnt;
    logic [CNT_WIDTH-1:0] inst_cnt;
    logic [31:0]          rdata_next;
    logic                 unused_bits;

    assign sel     = (addr[31:28] == IO_TAG);
    assign off     = addr[7:0];
    assign rd_en   = sel & re;
    assign wr_en   = sel & (|wbe);
    assign cnt_clr = wr_en & (off == MMIO_CNT_RST);

    assign unused_bits = &{1'b0, addr[27:8], wdata[31:8]};

    mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .clr   (cnt_clr),
        .count (cyc_cnt)
    );

    mmio_counter #(.CNT_WIDTH(CNT_WIDTH)) u_inst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inst_retire),
        .clr   (cnt_clr),
        .count (inst_cnt)
    );

    always_comb begin
        rdata_next = 32'h0;
        case (off)
            MMIO_STATUS: rdata_next = status_word(tx_pend, rx_full);
            MMIO_RX:     rdata_next = {24'h0, rx_buf};
            MMIO_CYC:    rdata_next = 32'(cyc_cnt);
            MMIO_INST:   rdata_next = 32'(inst_cnt);
            default:     rdata_next = 32'h0;
        endcase
    end

    // Unselected or non-load cycles leave rdata untouched so it behaves like a memory read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 32'h0;
        end else if (rd_en) begin
            rdata <= rdata_next;
        end
    end

    // Capture and read-clear are exclusive: capture needs rx_full=0, clearing needs rx_full=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_full <= 1'b0;
            rx_buf  <= 8'h0;
        end else if (rx_valid && !rx_full) begin
            rx_buf  <= rx_data;
            rx_full <= 1'b1;
        end else if (rd_en && (off == MMIO_RX)) begin
            rx_full <= 1'b0;
        end
    end

    assign rx_ready = ~rx_full;

    // A write arriving while a byte is pending is dropped, even on the handshake cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pend <= 1'b0;
            tx_buf  <= 8'h0;
        end else if (tx_pend) begin
            if (tx_ready) begin
                tx_pend <= 1'b0;
            end
        end else if (wr_en && (off == MMIO_TX) && wbe[0]) begin
            tx_buf  <= wdata[7:0];
            tx_pend <= 1'b1;
        end
    end

    assign tx_valid = tx_pend;
    assign tx_data  = tx_buf;

endmodule

// File: doc/mmio_uart_ctrl.md
# mmio_uart_ctrl

Memory-mapped I/O controller between the Riscv151 datapath's memory stage and the `uart_receiver`/`uart_transmitter` instances. It decodes load/store requests in the I/O region. It provides:
- a one-byte RX buffer and a one-byte TX holding register, each with a ready/valid handshake to the UART;
- cycle and retired-instruction counters.

Read data has one-cycle latency, matching the synchronous BIOS/DMEM read path, so the writeback mux treats I/O like memory.

## Interface
Parameters:
- `IO_TAG`, 4'h8: `addr[31:28]` value selecting this block.
- `CNT_WIDTH`, 32: counter width. Read data is zero-extended to 32 bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address from the memory stage.
- `re` in 1: load request this cycle.
- `wbe` in 4: store byte enables. Nonzero means a store.
- `wdata` in 32: store data.
- `rdata` out 32: registered load data.
- `inst_retire` in 1: one instruction retired this cycle.
- `rx_data` in 8, `rx_valid` in 1, `rx_ready` out 1: byte stream from `uart_receiver`.
- `tx_data` out 8, `tx_valid` out 1, `tx_ready` in 1: byte stream to `uart_transmitter`.

## Operation
- `sel = (addr[31:28] == IO_TAG)`. Requests with `sel=0` are ignored: no side effects, and `rdata` is not updated.
- Address map (offset is `addr[7:0]`):
  - 0x00 status (read): bit0 = `~tx_pend`, bit1 = `rx_full`, other bits 0.
  - 0x04 RX data (read): `{24'b0, rx_buf}`. If `rx_full`=1, clears `rx_full`.
  - 0x08 TX data (write, `wbe[0]`=1): if `tx_pend`=0, loads `tx_buf` ← `wdata[7:0]` and sets `tx_pend`. If `tx_pend`=1, the write is dropped silently.
  - 0x10 cycle counter (read).
  - 0x14 instruction counter (read).
  - 0x18 counter reset (any store): both counters ← 0.
  - Any other offset: load returns 0; store has no effect.
- RX handshake:
  - `rx_ready = ~rx_full` (combinational from the register).
  - On `rx_valid & rx_ready`: `rx_buf` ← `rx_data` and `rx_full` ← 1.
  - A RX data read with `rx_full`=0 returns the stale `rx_buf`, with no side effect.
- TX handshake:
  - `tx_valid = tx_pend` and `tx_data = tx_buf`.
  - `tx_valid` and `tx_data` stay stable until the cycle where `tx_valid & tx_ready`, after which `tx_pend` ← 0.
- Counters:
  - Cycle counter increments every cycle.
  - Instruction counter increments when `inst_retire`=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - In the cycle of a counter-reset store, the reset wins over the increment.
- Simultaneous `re` and store in the same cycle: the store takes effect at the clock edge. `rdata` returns the pre-edge values.

## Timing
- Reset values:
  - `rdata` = 0, `rx_ready` = 1, `tx_valid` = 0, `tx_data` = 0.
  - Internally: `rx_full` = 0, `tx_pend` = 0, `rx_buf` = 0, counters = 0.
- Reset asserted mid-transfer clears `tx_valid` asynchronously, abandoning the byte. A buffered RX byte is lost.
- Load latency: request on cycle N, and `rdata` is valid from the edge ending cycle N. The value is sampled from register state during cycle N. `rdata` holds until the next selected load.
- RX read side effect: `rx_full` = 0 and `rx_ready` = 1 from cycle N+1. A new byte can be captured at the end of cycle N+1.
- TX: a write in cycle N gives `tx_valid` = 1 in cycle N+1. The earliest re-write is accepted in the cycle after the handshake completes.
- Counter reset store in cycle N: a read in cycle N+1 returns 0 for the cycle counter. The cycle-counter value is 1 in cycle N+2.

## Structure
- Package `mmio_pkg` holds the offset constants (`MMIO_STATUS`, `MMIO_RX`, `MMIO_TX`, `MMIO_CYC`, `MMIO_INST`, `MMIO_CNT_RST`) and the status bit indices. Decoding in the core's writeback mux uses the same package.
- One sub-module, `mmio_counter`: CNT_WIDTH register with `inc` and `clr` inputs and async active-low reset. It is instantiated twice.
- RX buffer, TX holding register, and decode stay in the top module.

## Test plan
- Reset then read 0x80000000 → `rdata` = 0x00000001 the next cycle. `rx_ready` = 1 and `tx_valid` = 0 throughout.
- Drive `rx_data` = 0x5A with `rx_valid` for 1 cycle → status reads 0x3. Read 0x80000004 → 0x0000005A. Status then reads 0x1, and `rx_ready` returns to 1 one cycle after the read.
- Keep `rx_valid` high with 0xA5 while `rx_full` = 1 → `rx_ready` = 0 and the byte is not captured. After the RX read, 0xA5 is captured in the following cycle.
- Store 0x41 to 0x80000008 with `tx_ready` = 0 → `tx_valid` = 1 and `tx_data` = 0x41. Store 0x42 → dropped, and `tx_data` stays 0x41. Raise `tx_ready` → handshake, `tx_valid` = 0 next cycle, status bit0 = 1.
- Pulse `inst_retire` 7 times over 20 cycles, then read 0x80000014 → 7. Store to 0x80000018 → both counters read 0 one cycle later. Preload the cycle counter near 0xFFFFFFFF and check wrap to 0.
- Assert `rst_n` = 0 mid-TX (`tx_valid` = 1) → `tx_valid` falls without waiting for a clock edge. Loads with `addr[31:28]` = 4'h1 leave `rdata` unchanged.
